// File: rtl/score_pkg.sv
// Shared definitions for the score tracker: FSM encoding and BCD digit constants.
package score_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_OVER = 2'd2
    } state_t;

    localparam int         DIGIT_W       = 4;
    localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit of a ripple-carry counter; carry requests an increment of the next digit.
module bcd_digit
    import score_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic               inc,
    input  logic               clr,
    output logic [DIGIT_W-1:0] digit,
    output logic               carry
);

    assign carry = inc && (digit == BCD_MAX_DIGIT);

    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            digit <= '0;
        end else if (clr) begin
            digit <= '0;
        end else if (inc) begin
            digit <= carry ? '0 : digit + DIGIT_W'(1);
        end
    end

endmodule

// File: rtl/score_tracker.sv
// Game score unit: prescaled BCD score with saturation, level steps, game FSM and high score.
module score_tracker
    import score_pkg::*;
#(
    parameter int  TICK_DIV   = 50_000,
    parameter int  NUM_DIGITS = 4,
    parameter int  LEVEL_PTS  = 100,
    parameter int  MAX_LEVEL  = 7,
    localparam int LVL_W      = $clog2(MAX_LEVEL + 1),
    localparam int SCORE_W    = DIGIT_W * NUM_DIGITS
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic               hit,
    output logic [SCORE_W-1:0] score,
    output logic [SCORE_W-1:0] high_score,
    output logic [LVL_W-1:0]   level,
    output logic               running,
    output logic               game_over,
    output logic               new_high,
    output logic               tick
);

    localparam int PRE_W = $clog2(TICK_DIV);
    localparam int LP_W  = $clog2(LEVEL_PTS + 1);

    state_t           state, state_nxt;
    logic [PRE_W-1:0] prescale;
    logic [LP_W-1:0]  level_pts;
    logic             game_start, game_end, wrap, all_nines, score_inc;
    logic [NUM_DIGITS-1:0] dig_inc, dig_carry;

    assign game_start = start && (state == ST_IDLE || state == ST_OVER);
    assign game_end   = hit && (state == ST_RUN);
    assign wrap       = (state == ST_RUN) && !hit && (prescale == PRE_W'(TICK_DIV - 1));
    assign score_inc  = wrap && !all_nines;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_OVER: if (start) state_nxt = ST_RUN;
            ST_RUN:           if (hit)   state_nxt = ST_OVER;
            default:          state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        running   = (state == ST_RUN);
        game_over = (state == ST_OVER);
    end

    always_comb begin
        all_nines = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (score[DIGIT_W*i +: DIGIT_W] != BCD_MAX_DIGIT) all_nines = 1'b0;
        end
    end

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
        if (i == 0) begin : g_lsd
            assign dig_inc[i] = score_inc;
        end else begin : g_upper
            assign dig_inc[i] = dig_carry[i-1];
        end
        bcd_digit u_digit (
            .clk     (clk),
            .reset_n (reset_n),
            .inc     (dig_inc[i]),
            .clr     (game_start),
            .digit   (score[DIGIT_W*i +: DIGIT_W]),
            .carry   (dig_carry[i])
        );
    end

    // Increments stop at all nines, so the most significant digit can never carry out.
    a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n) !dig_carry[NUM_DIGITS-1]);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prescale   <= '0;
            level_pts  <= '0;
            level      <= '0;
            high_score <= '0;
            new_high   <= 1'b0;
            tick       <= 1'b0;
        end else begin
            tick <= score_inc;
            if (game_start) begin
                prescale  <= '0;
                level_pts <= '0;
                level     <= '0;
                new_high  <= 1'b0;
            end else if (game_end) begin
                if (score > high_score) begin
                    high_score <= score;
                    new_high   <= 1'b1;
                end
            end else if (state == ST_RUN) begin
                prescale <= wrap ? '0 : prescale + PRE_W'(1);
                if (score_inc) begin
                    if (level_pts == LP_W'(LEVEL_PTS - 1)) begin
                        level_pts <= '0;
                        if (level != LVL_W'(MAX_LEVEL)) level <= level + LVL_W'(1);
                    end else begin
                        level_pts <= level_pts + LP_W'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_score_tracker.sv
// Self-checking bench: directed game scenarios plus random start/hit traffic against an integer model.
module tb_score_tracker;

    localparam int TICK_DIV   = 4;
    localparam int NUM_DIGITS = 2;
    localparam int LEVEL_PTS  = 3;
    localparam int MAX_LEVEL  = 2;
    localparam int SCORE_W    = 4 * NUM_DIGITS;
    localparam int LVL_W      = $clog2(MAX_LEVEL + 1);
    localparam int MAX_SCORE  = 99;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_OVER = 2;

    logic               clk = 1'b0;
    logic               reset_n;
    logic               start;
    logic               hit;
    logic [SCORE_W-1:0] score;
    logic [SCORE_W-1:0] high_score;
    logic [LVL_W-1:0]   level;
    logic               running;
    logic               game_over;
    logic               new_high;
    logic               tick;

    int total = 0;
    int bad   = 0;

    // Reference model: plain decimal integers, converted to BCD only for comparison.
    int m_state, m_score, m_high, m_level, m_pts, m_pre;
    bit m_new, m_tick;

    score_tracker #(
        .TICK_DIV   (TICK_DIV),
        .NUM_DIGITS (NUM_DIGITS),
        .LEVEL_PTS  (LEVEL_PTS),
        .MAX_LEVEL  (MAX_LEVEL)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .hit        (hit),
        .score      (score),
        .high_score (high_score),
        .level      (level),
        .running    (running),
        .game_over  (game_over),
        .new_high   (new_high),
        .tick       (tick)
    );

    always #5 clk = ~clk;

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [SCORE_W-1:0] to_bcd(input int v);
        logic [SCORE_W-1:0] r;
        r = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    task automatic model_reset();
        m_state = M_IDLE; m_score = 0; m_high = 0; m_level = 0;
        m_pts = 0; m_pre = 0; m_new = 0; m_tick = 0;
    endtask

    task automatic model_edge(input bit s, input bit h);
        m_tick = 0;
        if (m_state != M_RUN) begin
            if (s) begin
                m_state = M_RUN; m_score = 0; m_level = 0; m_pts = 0; m_pre = 0; m_new = 0;
            end
        end else if (h) begin
            m_state = M_OVER;
            if (m_score > m_high) begin
                m_high = m_score;
                m_new  = 1;
            end
        end else begin
            m_pre = (m_pre + 1) % TICK_DIV;
            if (m_pre == 0 && m_score < MAX_SCORE) begin
                m_score++;
                m_tick = 1;
                m_pts++;
                if (m_pts == LEVEL_PTS) begin
                    m_pts = 0;
                    if (m_level < MAX_LEVEL) m_level++;
                end
            end
        end
    endtask

    task automatic check_all();
        check("score",      score,      to_bcd(m_score));
        check("high_score", high_score, to_bcd(m_high));
        check("level",      level,      m_level);
        check("running",    running,    m_state == M_RUN);
        check("game_over",  game_over,  m_state == M_OVER);
        check("new_high",   new_high,   m_new);
        check("tick",       tick,       m_tick);
    endtask

    task automatic cycle(input bit s, input bit h);
        start = s;
        hit   = h;
        @(posedge clk);
        model_edge(s, h);
        #1;
        check_all();
    endtask

    // Reset is asserted between edges; outputs must clear before any clock arrives.
    task automatic do_reset();
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_all();
        check("rst_running", running, 1'b0);
        start = 1'b0;
        hit   = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic run_to(input int target);
        for (int i = 0; i < 1000 && m_score != target; i++) cycle(1'b0, 1'b0);
        check("run_to_reached", m_score, target);
    endtask

    initial begin
        reset_n = 1'b0;
        start   = 1'b0;
        hit     = 1'b0;
        model_reset();
        #12;
        check_all();
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Reset in the middle of a game at score 05.
        cycle(1'b1, 1'b0);
        run_to(5);
        check("t1_pre_score", score, 8'h05);
        do_reset();
        check("t1_score", score, 8'h00);

        // Forty running cycles: ten points, level saturated.
        cycle(1'b1, 1'b0);
        repeat (40) cycle(1'b0, 1'b0);
        check("t2_score", score, 8'h10);
        check("t2_level", level, 2);
        do_reset();

        // Hit exactly on a prescaler wrap at 07.
        cycle(1'b1, 1'b0);
        for (int i = 0; i < 200 && !(m_score == 7 && m_pre == TICK_DIV - 1); i++) cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b1);
        check("t3_score", score, 8'h07);
        check("t3_over", game_over, 1'b1);
        check("t3_high", high_score, 8'h07);
        check("t3_new_high", new_high, 1'b1);
        check("t3_tick", tick, 1'b0);

        // Lower and equal scores leave the high score alone.
        cycle(1'b1, 1'b0);
        run_to(5);
        cycle(1'b0, 1'b1);
        check("t4a_high", high_score, 8'h07);
        check("t4a_new_high", new_high, 1'b0);
        cycle(1'b1, 1'b0);
        run_to(7);
        cycle(1'b0, 1'b1);
        check("t4b_high", high_score, 8'h07);
        check("t4b_new_high", new_high, 1'b0);

        // Long run into saturation.
        cycle(1'b1, 1'b0);
        repeat (420) cycle(1'b0, 1'b0);
        check("t5_score", score, 8'h99);
        check("t5_level", level, 2);
        check("t5_tick", tick, 1'b0);
        cycle(1'b0, 1'b1);
        check("t5_high", high_score, 8'h99);

        // Hit ignored in IDLE; start+hit together in OVER starts a new game.
        do_reset();
        cycle(1'b0, 1'b1);
        check("t6_idle_over", game_over, 1'b0);
        cycle(1'b1, 1'b0);
        run_to(3);
        cycle(1'b0, 1'b1);
        cycle(1'b1, 1'b1);
        check("t6_running", running, 1'b1);
        check("t6_score", score, 8'h00);

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 999) == 0) do_reset();
            cycle($urandom_range(0, 39) == 0, $urandom_range(0, 69) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
